// File: rtl/mips_pkg.sv
// Shared MIPS datapath types and constants.
// Sizes here set the default data memory geometry.
package mips_pkg;

   localparam int WORD_BYTES       = 4;
   localparam int DATA_WIDTH       = 32;
   localparam int MEM_ADDR_BITS    = 8;

   typedef logic [7:0]            byte_t;
   typedef logic [DATA_WIDTH-1:0] word_t;

endpackage

// File: rtl/data_memory.sv
// MEM-stage byte-addressed data memory: big-endian 32-bit words, synchronous
// write, combinational read, byte lanes wrap around the end of the array.
module data_memory
   import mips_pkg::*;
#(
   parameter int ADDR_BITS  = MEM_ADDR_BITS,
   parameter int DATA_WIDTH = mips_pkg::DATA_WIDTH
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [31:0]           address,
   input  logic [DATA_WIDTH-1:0] write_data,
   input  logic                  memory_read,
   input  logic                  memory_write,
   output logic [DATA_WIDTH-1:0] read_data
);

   localparam int DEPTH = 2 ** ADDR_BITS;

   byte_t                mem [DEPTH];
   logic [ADDR_BITS-1:0] base;
   logic                 unused_addr;

   assign base        = address[ADDR_BITS-1:0];
   assign unused_addr = ^address[31:ADDR_BITS];

   // Byte lane k of a word at index a; the add truncates, giving mod-depth wrap.
   function automatic logic [ADDR_BITS-1:0] lane(input logic [ADDR_BITS-1:0] a,
                                                 input int unsigned k);
      return a + ADDR_BITS'(k);
   endfunction

   // NOTE: sequential state uses non-blocking assignments so every lane update
   // in the loop sees the same pre-edge values and ordering between blocks is safe.
   // NOTE: the array is cleared on reset because software expects zeroed data
   // memory; this costs a reset net on every byte but is required behaviour.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem[i] <= '0;
         end
      end else if (memory_write) begin
         for (int k = 0; k < WORD_BYTES; k++) begin
            mem[lane(base, k)] <= write_data[DATA_WIDTH-1-8*k -: 8];
         end
      end
   end

   always_comb begin
      read_data = '0;
      if (memory_read && !rst) begin
         for (int k = 0; k < WORD_BYTES; k++) begin
            read_data[DATA_WIDTH-1-8*k -: 8] = mem[lane(base, k)];
         end
      end
   end

endmodule

// File: tb/tb_data_memory.sv
// Self-checking bench for data_memory: table-driven vectors with a scoreboard
// queue, plus hand-written reset and same-cycle read/write sequences.
module tb_data_memory;

   logic        clk;
   logic        rst;
   logic [31:0] address;
   logic [31:0] write_data;
   logic        memory_read;
   logic        memory_write;
   logic [31:0] read_data;

   int tests_run;
   int tests_failed;

   logic [31:0] exp_q [$];

   typedef struct {
      string       name;
      logic        is_clk;   // 1: step one clock edge, 0: combinational read
      logic        we;
      logic        re;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [31:0] exp;
   } vec_t;

   vec_t vecs [$];

   data_memory dut (
      .clk          (clk),
      .rst          (rst),
      .address      (address),
      .write_data   (write_data),
      .memory_read  (memory_read),
      .memory_write (memory_write),
      .read_data    (read_data)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests_run++;
      if (act !== exp) begin
         tests_failed++;
         $display("FAIL %s: read_data=%h expected=%h", name, act, exp);
      end
   endtask

   // Drive a read, record the expectation, then compare once the output settles.
   task automatic do_read(input string name, input logic [31:0] addr, input logic re,
                          input logic [31:0] exp);
      address      = addr;
      memory_read  = re;
      memory_write = 1'b0;
      exp_q.push_back(exp);
      #1;
      check(name, read_data, exp_q.pop_front());
   endtask

   task automatic do_edge(input logic [31:0] addr, input logic we, input logic [31:0] wdata);
      address      = addr;
      write_data   = wdata;
      memory_write = we;
      memory_read  = 1'b0;
      @(posedge clk);
      #1;
      memory_write = 1'b0;
   endtask

   initial begin
      tests_run    = 0;
      tests_failed = 0;
      rst          = 1'b1;
      address      = '0;
      write_data   = '0;
      memory_read  = 1'b0;
      memory_write = 1'b0;

      // Reset state
      @(posedge clk);
      #1;
      do_read("reset_state", 32'h10, 1'b1, 32'h0);
      rst = 1'b0;
      #1;

      // Asynchronous reset mid-operation
      do_edge(32'h10, 1'b1, 32'h12345678);
      do_read("pre_reset_data", 32'h10, 1'b1, 32'h12345678);
      #2;
      rst = 1'b1;
      do_read("async_reset_clear", 32'h10, 1'b1, 32'h0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      do_read("held_clear_after_reset", 32'h10, 1'b1, 32'h0);

      vecs.push_back('{"w_deadbeef",     1'b1, 1'b1, 1'b0, 32'h0000_0020, 32'hDEADBEEF, 32'h0});
      vecs.push_back('{"basic_read",     1'b0, 1'b0, 1'b1, 32'h0000_0020, 32'h0,        32'hDEADBEEF});
      vecs.push_back('{"byte_23",        1'b0, 1'b0, 1'b1, 32'h0000_0023, 32'h0,        32'hEF000000});
      vecs.push_back('{"upper_ignored",  1'b0, 1'b0, 1'b1, 32'h1234_5620, 32'h0,        32'hDEADBEEF});
      vecs.push_back('{"read_disabled",  1'b0, 1'b0, 1'b0, 32'h0000_0020, 32'h0,        32'h0});
      vecs.push_back('{"no_write_edge",  1'b1, 1'b0, 1'b0, 32'h0000_0020, 32'h0BADF00D, 32'h0});
      vecs.push_back('{"unchanged",      1'b0, 1'b0, 1'b1, 32'h0000_0020, 32'h0,        32'hDEADBEEF});
      vecs.push_back('{"w_wrap",         1'b1, 1'b1, 1'b0, 32'hFFFF_FFFF, 32'hFFFFFFFF, 32'h0});
      vecs.push_back('{"wrap_read_ff",   1'b0, 1'b0, 1'b1, 32'h0000_00FF, 32'h0,        32'hFFFFFFFF});
      vecs.push_back('{"wrap_read_00",   1'b0, 1'b0, 1'b1, 32'h0000_0000, 32'h0,        32'hFFFFFF00});
      vecs.push_back('{"w_aabbccdd",     1'b1, 1'b1, 1'b0, 32'h0000_0000, 32'hAABBCCDD, 32'h0});
      vecs.push_back('{"w_01020304",     1'b1, 1'b1, 1'b0, 32'h0000_0002, 32'h01020304, 32'h0});
      vecs.push_back('{"overlap_00",     1'b0, 1'b0, 1'b1, 32'h0000_0000, 32'h0,        32'hAABB0102});
      vecs.push_back('{"overlap_03",     1'b0, 1'b0, 1'b1, 32'h0000_0003, 32'h0,        32'h02030400});
      vecs.push_back('{"overlap_wrap",   1'b0, 1'b0, 1'b1, 32'h0000_00FF, 32'h0,        32'hFFAABB01});

      for (int i = 0; i < vecs.size(); i++) begin
         if (vecs[i].is_clk) begin
            do_edge(vecs[i].addr, vecs[i].we, vecs[i].wdata);
         end else begin
            do_read(vecs[i].name, vecs[i].addr, vecs[i].re, vecs[i].exp);
         end
      end

      // Same-cycle read and write to one address
      do_edge(32'h40, 1'b1, 32'h11111111);
      address      = 32'h40;
      write_data   = 32'h22222222;
      memory_read  = 1'b1;
      memory_write = 1'b1;
      exp_q.push_back(32'h11111111);
      #1;
      check("rw_before_edge", read_data, exp_q.pop_front());
      exp_q.push_back(32'h22222222);
      @(posedge clk);
      #1;
      memory_write = 1'b0;
      check("rw_after_edge", read_data, exp_q.pop_front());

      // Reset wins over a write on the same edge
      address      = 32'h40;
      write_data   = 32'h33333333;
      memory_write = 1'b1;
      rst          = 1'b1;
      @(posedge clk);
      #1;
      memory_write = 1'b0;
      rst          = 1'b0;
      do_read("reset_priority", 32'h40, 1'b1, 32'h0);
      do_read("reset_cleared_wrap", 32'hFF, 1'b1, 32'h0);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
